// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC generation plus an IF->ID queue of {pc, pc+step, instr}.
// Redirect from EX flushes the queue and reloads the PC.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          instruction,
    input  logic                     instr_valid,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     dec_ready,
    output logic [XLEN-1:0]          pc_if,
    output logic                     dec_valid,
    output logic [XLEN-1:0]          dec_pc,
    output logic [XLEN-1:0]          dec_pc_plus_4,
    output logic [XLEN-1:0]          dec_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc_d, pc_q;
    logic [AW-1:0]   rd_ptr_d, rd_ptr_q;
    logic [AW-1:0]   wr_ptr_d, wr_ptr_q;
    logic [CW-1:0]   count_d, count_q;
    logic            push, pop;
    logic            full_w;

    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [XLEN-1:0] mem_pc4_q   [DEPTH];
    logic [XLEN-1:0] mem_instr_q [DEPTH];

    assign full_w = (count_q == CW'(DEPTH));

    always_comb begin
        pop      = (count_q != '0) && dec_ready && !redirect_valid;
        push     = instr_valid && !redirect_valid && (!full_w || pop);
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + STEP;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; occupancy alone qualifies the data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_pc4_q[wr_ptr_q]   <= pc_q + STEP;
            mem_instr_q[wr_ptr_q] <= instruction;
        end
    end

    assign pc_if         = pc_q;
    assign count         = count_q;
    assign full          = full_w;
    assign dec_valid     = (count_q != '0);
    assign dec_pc        = mem_pc_q[rd_ptr_q];
    assign dec_pc_plus_4 = mem_pc4_q[rd_ptr_q];
    assign dec_instr     = mem_instr_q[rd_ptr_q];

endmodule
